div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one `sequential_divider` instance among NUM_REQ requesters using a round-robin arbiter. Example requesters: the CPU DIV/MOD execute path and a peripheral/accelerator port.
- Accepts one request at a time and sequences the divider's start/done protocol.
- Captures the result and returns it to the winning requester over a valid/ready response handshake.
- The divider is instantiated inside this block and shares its clock and reset.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ID_W, 1, width of resp_id; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_dividend  in  16*NUM_REQ  packed dividends; requester i uses bits [16i+15:16i].
- req_divisor  in  16*NUM_REQ  packed divisors, same packing as req_dividend.
- resp_valid  out  NUM_REQ  one-hot response valid, to the requester that was granted.
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_id  out  ID_W  index of the requester owning the current response.
- resp_quotient  out  16  quotient.
- resp_remainder  out  16  remainder.
- resp_div_by_zero  out  1  divisor was 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset, applied synchronously on a clk edge with reset=1:
  - FSM goes to IDLE; round-robin pointer is set so requester 0 has top priority.
  - req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, resp_div_by_zero, busy are all 0.
  - The internal divider is reset by the same signal.
- Reset mid-operation aborts the in-flight division; no response is ever produced for it.
- FSM states:
  - IDLE:
    - req_ready = the one-hot grant of the round-robin search.
    - The search starts at (last_grant+1) mod NUM_REQ and covers only requesters with req_valid high.
    - req_ready is combinational from req_valid.
    - On a grant: latch operands and the requester index, update last_grant, go to ISSUE.
    - With no valid request, stay in IDLE.
  - ISSUE: drive divider start=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold start=0; on divider done=1, capture the result and go to RESP.
    - Capture: quotient, remainder, div_by_zero.
    - If div_by_zero: force quotient=0xFFFF and remainder=latched dividend.
  - RESP:
    - Hold resp_valid[id]=1 and keep resp_* stable until resp_ready[id]=1.
    - Then clear resp_valid and go to IDLE.
    - resp_ready bits of other requesters are ignored.
- Latency: accept at cycle T, start at T+1, done at T+18, resp_valid from T+19.
- Next accept: earliest at the cycle after the response handshake; no back-to-back overlap.
- Outstanding requests: exactly one. req_ready is 0 in ISSUE, WAIT and RESP.
- Requests still pending when a grant is made keep req_valid high; the arbiter considers them again in the next IDLE.
- A requester that drops req_valid before it is granted is simply skipped.
- Operands are sampled only in the accept cycle; later changes on req_dividend/req_divisor have no effect.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...
- A done seen outside WAIT is ignored; this cannot occur in a correct design and the bench asserts it never happens.
- Arithmetic is unsigned 16-bit, except when the optional signed feature below is compiled in.

Optional Feature:
- Macro: DIV_ARB_SIGNED_EN.
- With the macro defined:
  - Adds input req_signed[NUM_REQ], sampled at accept.
  - For signed requests, the divider is fed the absolute values of the operands.
  - In WAIT→RESP, the quotient is negated (two's complement) when the operand signs differ.
  - The remainder takes the dividend's sign.
  - Divide-by-zero still returns 0xFFFF and the raw dividend.
  - 0x8000 / 0xFFFF returns quotient 0x8000 (wraps), remainder 0.
  - Adds one extra FIXUP state between WAIT and RESP, so latency becomes T+20.
- Without the macro: no req_signed port, unsigned only, latency T+19.

Test Plan:
- Reset held 3 cycles during WAIT, then released → all outputs 0; no resp_valid within 40 cycles; a new request is accepted normally.
- Req0: 1000/7 → accepted at T; resp_valid[0] at T+19; quotient=142, remainder=6, div_by_zero=0, resp_id=0.
- Req1: 0x1234/0 → quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
- Req0 and req1 both valid continuously with resp_ready tied high → grants alternate 0,1,0,1; each response matches its own operands.
- resp_ready[0] held low for 10 cycles → resp_valid and data stay stable the whole time; req_ready stays 0; no new grant until the handshake.
- Signed mode (DIV_ARB_SIGNED_EN):
  - −100/7 → quotient 0xFFF2 (−14), remainder 0xFFFE (−2).
  - 0x8000/0xFFFF → quotient 0x8000, remainder 0.
  - Response at T+20.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one 16-bit sequential divider among
// NUM_REQ requesters, with one outstanding request at a time.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (also resets the divider)
//   req_valid/ready   per-requester request handshake; req_ready is the one-hot
//                     round-robin grant, combinational from req_valid in IDLE
//   req_dividend      packed 16-bit dividends, requester i at [16i+15:16i]
//   req_divisor       packed 16-bit divisors, same packing
//   req_signed        per-requester signed flag (only with DIV_ARB_SIGNED_EN)
//   resp_valid/ready  one-hot response handshake to the granted requester
//   resp_id           index of the requester owning the response
//   resp_quotient     quotient (0xFFFF on divide-by-zero)
//   resp_remainder    remainder (raw dividend on divide-by-zero)
//   resp_div_by_zero  divisor was zero
//   busy              FSM is not in IDLE
//
// Optional feature: define DIV_ARB_SIGNED_EN for signed division support.
// This adds a FIXUP state, so the response appears one cycle later.

// Restoring divider: start loads the operands, 16 iterations follow, and done
// pulses for one cycle 17 cycles after start, with the result held stable.
module sequential_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);
    logic [15:0] den;
    logic [4:0]  cnt;
    logic [16:0] shifted;
    logic [16:0] diff;
    logic        ge;
    logic [15:0] step_r;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted = {remainder, quotient[15]};
        diff    = shifted - {1'b0, den};
        ge      = (shifted >= {1'b0, den});
        step_r  = ge ? 16'(diff) : 16'(shifted);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            den         <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                den         <= divisor;
                cnt         <= 5'd16;
                quotient    <= dividend;
                remainder   <= '0;
                div_by_zero <= (divisor == 16'd0);
            end else if (cnt != 5'd0) begin
                remainder <= step_r;
                quotient  <= {quotient[14:0], ge};
                cnt       <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

module div_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_dividend,
    input  logic [16*NUM_REQ-1:0]   req_divisor,
`ifdef DIV_ARB_SIGNED_EN
    input  logic [NUM_REQ-1:0]      req_signed,
`endif
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [15:0]             resp_quotient,
    output logic [15:0]             resp_remainder,
    output logic                    resp_div_by_zero,
    output logic                    busy
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIXUP,
        S_RESP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   op_id;
    logic [15:0]        op_dividend;
    logic [15:0]        op_divisor;
`ifdef DIV_ARB_SIGNED_EN
    logic               op_signed;
    logic               sel_signed;
`endif

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        sel_dividend;
    logic [15:0]        sel_divisor;

    logic               div_start;
    logic [15:0]        div_a;
    logic [15:0]        div_b;
    logic               div_done;
    logic [15:0]        div_q;
    logic [15:0]        div_r;
    logic               div_dz;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((32'(last_grant) + k) % NUM_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
`ifdef DIV_ARB_SIGNED_EN
        sel_signed   = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_dividend = req_dividend[16*i +: 16];
                sel_divisor  = req_divisor[16*i +: 16];
`ifdef DIV_ARB_SIGNED_EN
                sel_signed   = req_signed[i];
`endif
            end
        end
    end

    assign req_ready = (state == S_IDLE && !reset) ? grant : '0;
    assign div_start = (state == S_ISSUE);

    // Signed requests run the divider on magnitudes; signs are restored in FIXUP.
`ifdef DIV_ARB_SIGNED_EN
    assign div_a = (op_signed && op_dividend[15]) ? -op_dividend : op_dividend;
    assign div_b = (op_signed && op_divisor[15])  ? -op_divisor  : op_divisor;
`else
    assign div_a = op_dividend;
    assign div_b = op_divisor;
`endif

    sequential_divider u_div (
        .clk         (clk),
        .reset       (reset),
        .start       (div_start),
        .dividend    (div_a),
        .divisor     (div_b),
        .done        (div_done),
        .quotient    (div_q),
        .remainder   (div_r),
        .div_by_zero (div_dz)
    );

    // Control FSM and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            last_grant       <= IDX_W'(NUM_REQ - 1);
            op_id            <= '0;
            op_dividend      <= '0;
            op_divisor       <= '0;
`ifdef DIV_ARB_SIGNED_EN
            op_signed        <= 1'b0;
`endif
            resp_valid       <= '0;
            resp_id          <= '0;
            resp_quotient    <= '0;
            resp_remainder   <= '0;
            resp_div_by_zero <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        op_id       <= grant_idx;
                        op_dividend <= sel_dividend;
                        op_divisor  <= sel_divisor;
`ifdef DIV_ARB_SIGNED_EN
                        op_signed   <= sel_signed;
`endif
                        last_grant  <= grant_idx;
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (div_done) begin
                        resp_quotient    <= div_dz ? 16'hFFFF : div_q;
                        resp_remainder   <= div_dz ? op_dividend : div_r;
                        resp_div_by_zero <= div_dz;
                        resp_id          <= ID_W'(op_id);
`ifdef DIV_ARB_SIGNED_EN
                        state            <= S_FIXUP;
`else
                        resp_valid       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << op_id;
                        state            <= S_RESP;
`endif
                    end
                end
`ifdef DIV_ARB_SIGNED_EN
                S_FIXUP: begin
                    if (op_signed && !resp_div_by_zero) begin
                        if (op_dividend[15] ^ op_divisor[15]) begin
                            resp_quotient <= -resp_quotient;
                        end
                        if (op_dividend[15]) begin
                            resp_remainder <= -resp_remainder;
                        end
                    end
                    resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << op_id;
                    state      <= S_RESP;
                end
`endif
                S_RESP: begin
                    // Only the owning requester's ready can complete the response.
                    if ((resp_ready & resp_valid) != '0) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: accepts are observed and the expected
// response is queued from a plain arithmetic model; a monitor checks grants,
// latency, response data and stability against the queue.
module tb_div_arbiter;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 1;
`ifdef DIV_ARB_SIGNED_EN
    localparam int LAT = 20;
`else
    localparam int LAT = 19;
`endif
    localparam int WDOG = 20000;

    typedef struct {
        int          id;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          t;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_dividend;
    logic [16*NUM_REQ-1:0] req_divisor;
    logic [NUM_REQ-1:0]    req_signed;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [15:0]           resp_quotient;
    logic [15:0]           resp_remainder;
    logic                  resp_div_by_zero;
    logic                  busy;

    always #5 clk = ~clk;

    div_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_dividend     (req_dividend),
        .req_divisor      (req_divisor),
`ifdef DIV_ARB_SIGNED_EN
        .req_signed       (req_signed),
`endif
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_id          (resp_id),
        .resp_quotient    (resp_quotient),
        .resp_remainder   (resp_remainder),
        .resp_div_by_zero (resp_div_by_zero),
        .busy             (busy)
    );

    // Reference result from plain arithmetic.
    function automatic exp_t model(int id, logic [15:0] a, logic [15:0] b, logic sgn, int t);
        exp_t e;
        int   sa;
        int   sb;
        logic use_s;
`ifdef DIV_ARB_SIGNED_EN
        use_s = sgn;
`else
        use_s = 1'b0 & sgn;
`endif
        e.id = id;
        e.t  = t;
        if (b == 16'd0) begin
            e.q  = 16'hFFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (use_s) begin
            sa   = int'($signed(a));
            sb   = int'($signed(b));
            e.q  = 16'(sa / sb);
            e.r  = 16'(sa % sb);
            e.dz = 1'b0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Next requester in round-robin order after 'last' that has valid high.
    function automatic int pick(int last, logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            if (v[(last + k) % int'(NUM_REQ)]) return (last + k) % int'(NUM_REQ);
        end
        return -1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    exp_t               sb[$];
    exp_t               e;
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 rst_neg = 0;
    int                 last_grant = NUM_REQ - 1;
    int                 g;
    int                 gid;
    bit                 holding = 1'b0;
    logic [NUM_REQ-1:0] oh;
    int                 tmo_cnt = 0;
    bit                 drv_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (cyc > WDOG) begin
            errors++;
            $display("FAIL watchdog: cycle %0d reached without completion", cyc);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        if (reset) begin
            rst_neg++;
            sb.delete();
            holding    = 1'b0;
            last_grant = NUM_REQ - 1;
            if (rst_neg >= 2) begin
                checks++;
                if (req_ready != '0 || resp_valid != '0 || resp_id != '0 || resp_quotient != '0 ||
                    resp_remainder != '0 || resp_div_by_zero != 1'b0 || busy != 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: rdy=%b rv=%b id=%0d q=%h r=%h dz=%b busy=%b, required all 0",
                             req_ready, resp_valid, resp_id, resp_quotient, resp_remainder,
                             resp_div_by_zero, busy);
                end
            end
        end else begin
            rst_neg = 0;
            // Grant prediction in IDLE, no grants otherwise.
            if (busy) begin
                checks++;
                if (req_ready != '0) begin
                    errors++;
                    $display("FAIL ready_while_busy: req_ready=%b, required 0", req_ready);
                end
            end else begin
                oh = '0;
                g  = pick(last_grant, req_valid);
                if (g >= 0) oh[g] = 1'b1;
                checks++;
                if (req_ready != oh) begin
                    errors++;
                    $display("FAIL grant: req_ready=%b, required %b (valid=%b last=%0d)",
                             req_ready, oh, req_valid, last_grant);
                end
            end
            if ((req_valid & req_ready) != '0) begin
                gid = 0;
                for (int i = 0; i < int'(NUM_REQ); i++) if (req_ready[i]) gid = i;
                sb.push_back(model(gid, req_dividend[16*gid +: 16], req_divisor[16*gid +: 16],
                                   req_signed[gid], cyc));
                last_grant = gid;
            end
            if (dut.div_done) begin
                checks++;
                if (!busy || resp_valid != '0) begin
                    errors++;
                    $display("FAIL done_outside_wait: busy=%b resp_valid=%b, required busy=1 resp_valid=0",
                             busy, resp_valid);
                end
            end
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: resp_valid=%b with nothing outstanding", resp_valid);
                end else begin
                    e = sb[0];
                    if (!holding) begin
                        checks++;
                        if (cyc != e.t + LAT) begin
                            errors++;
                            $display("FAIL latency: resp at cycle %0d, required %0d", cyc, e.t + LAT);
                        end
                        holding = 1'b1;
                    end
                    oh = '0;
                    oh[e.id] = 1'b1;
                    checks++;
                    if (resp_valid != oh || int'(resp_id) != e.id || resp_quotient != e.q ||
                        resp_remainder != e.r || resp_div_by_zero != e.dz) begin
                        errors++;
                        $display("FAIL resp: rv=%b id=%0d q=%h r=%h dz=%b, required rv=%b id=%0d q=%h r=%h dz=%b",
                                 resp_valid, resp_id, resp_quotient, resp_remainder, resp_div_by_zero,
                                 oh, e.id, e.q, e.r, e.dz);
                    end
                    if (resp_ready[e.id]) begin
                        void'(sb.pop_front());
                        holding = 1'b0;
                    end
                end
            end
        end
        if (drv_done) begin
            checks++;
            if (tmo_cnt != 0) begin
                errors++;
                $display("FAIL handshake_timeout: %0d waits expired, required 0", tmo_cnt);
            end
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL pending: %0d responses outstanding, required 0", sb.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_accept(int i);
        int n = 0;
        @(negedge clk);
        while (!req_ready[i]) begin
            n++;
            if (n > 200) begin
                tmo_cnt++;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic issue(int i, logic [15:0] a, logic [15:0] b, logic s);
        @(posedge clk);
        #1;
        req_dividend[16*i +: 16] = a;
        req_divisor[16*i +: 16]  = b;
        req_signed[i]            = s;
        req_valid[i]             = 1'b1;
        wait_accept(i);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((busy || resp_valid != '0) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) tmo_cnt++;
    endtask

    function automatic logic [15:0] rnd_divisor();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'($urandom_range(2, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic rnd_signed();
`ifdef DIV_ARB_SIGNED_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        int n;
        reset        = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        req_signed   = '0;
        resp_ready   = '1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Directed: plain division and divide-by-zero.
        issue(0, 16'd1000, 16'd7, 1'b0);
        drain();
        issue(1, 16'h1234, 16'h0000, 1'b0);
        drain();
`ifdef DIV_ARB_SIGNED_EN
        issue(0, 16'hFF9C, 16'd7, 1'b1);
        drain();
        issue(1, 16'h8000, 16'hFFFF, 1'b1);
        drain();
`endif

        // Reset in the middle of a division; nothing may come back.
        issue(0, 16'd5000, 16'd3, 1'b0);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        issue(1, 16'd4321, 16'd10, 1'b0);
        drain();

        // Both requesters continuously valid: grants must alternate.
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_dividend[16*i +: 16] = 16'($urandom);
            req_divisor[16*i +: 16]  = rnd_divisor();
            req_signed[i]            = rnd_signed();
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == '0 && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (n >= 200) tmo_cnt++;
            g = 0;
            for (int i = 0; i < int'(NUM_REQ); i++) if (req_ready[i]) g = i;
            @(posedge clk);
            #1;
            req_dividend[16*g +: 16] = 16'($urandom);
            req_divisor[16*g +: 16]  = rnd_divisor();
        end
        req_valid = '0;
        drain();

        // Response back-pressure on requester 0 while requester 1 waits.
        resp_ready = '0;
        issue(0, 16'd60000, 16'd123, 1'b0);
        req_dividend[31:16] = 16'd777;
        req_divisor[31:16]  = 16'd5;
        req_signed[1]       = 1'b0;
        req_valid[1]        = 1'b1;
        n = 0;
        @(negedge clk);
        while (!resp_valid[0] && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) tmo_cnt++;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 resp_ready = '1;
        wait_accept(1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        drain();

        // Random traffic: valids drop, operands change every cycle, random back-pressure.
        repeat (400) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                req_valid[i]             = ($urandom_range(0, 3) != 0);
                req_dividend[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                req_divisor[16*i +: 16]  = rnd_divisor();
                req_signed[i]            = rnd_signed();
                resp_ready[i]            = ($urandom_range(0, 2) != 0);
            end
        end
        @(posedge clk);
        #1;
        req_valid  = '0;
        resp_ready = '1;
        drain();

        drv_done = 1'b1;
    end
endmodule
